// File: rtl/seqdet_stream_ctrl.sv
// seqdet_stream_ctrl
//   Word-to-bit scheduler for a bit-serial 10010 pattern detector. Words
//   arrive over a valid/ready handshake and are shifted out MSB-first, one
//   bit per clock, with no gap between consecutive words. The block owns
//   the detector's active-low reset. It counts detector hits and finishes a
//   run when the count reaches a programmed threshold.
//
// Parameters
//   W   data word width (>= 2)
//   CW  width of threshold and match counter
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   start       arm pulse, honoured only when idle or done
//   abort       return to idle from any state
//   cfg_thresh  hit count that ends a run, captured on an accepted start
//   din         data word
//   din_valid   word present
//   din_ready   controller can take a word
//   det_x       serial bit to the detector
//   det_rst_n   detector reset, active-low; released only while shifting
//   det_z       detector hit, combinational from det_x
//   busy        run in progress (LOAD or SHIFT)
//   done        threshold reached; held until start or abort
//   underrun    sticky: the stream ran dry mid-run; cleared on start
//   match_cnt   hits counted in the current run
//   first_hit   (SEQDET_CTRL_TSTAMP_EN only) number of bits shifted since
//               start, counted from 0, at the first hit; 16'hFFFF until then
//
// Build option
//   SEQDET_CTRL_TSTAMP_EN  adds the first_hit port and its bit counter

module seqdet_stream_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_thresh,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          det_x,
    output logic          det_rst_n,
    input  logic          det_z,
    output logic          busy,
    output logic          done,
    output logic          underrun,
    output logic [CW-1:0] match_cnt
`ifdef SEQDET_CTRL_TSTAMP_EN
    ,
    output logic [15:0]   first_hit
`endif
);

    localparam int unsigned BW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  sr, sr_n;
    logic [BW-1:0] bidx, bidx_n;
    logic [W-1:0]  hold, hold_n;
    logic          hold_v, hold_v_n;
    logic [CW-1:0] thr, thr_n;
    logic [CW-1:0] cnt_n;
    logic          done_n;
    logic          under_n;
    logic          accept;
    logic          hit;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            bidx      <= '0;
            hold      <= '0;
            hold_v    <= 1'b0;
            thr       <= '0;
            match_cnt <= '0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bidx      <= bidx_n;
            hold      <= hold_n;
            hold_v    <= hold_v_n;
            thr       <= thr_n;
            match_cnt <= cnt_n;
            done      <= done_n;
            underrun  <= under_n;
        end
    end

    always_comb begin
        // Handshake and detector controls depend on state only.
        din_ready = (state == LOAD) || ((state == SHIFT) && !hold_v);
        det_rst_n = (state == SHIFT);
        det_x     = (state == SHIFT) ? sr[W-1] : 1'b0;
        busy      = (state == LOAD) || (state == SHIFT);

        accept  = din_valid && din_ready;
        hit     = (state == SHIFT) && det_z;
        cnt_inc = match_cnt + CW'(1);

        state_n  = state;
        sr_n     = sr;
        bidx_n   = bidx;
        hold_n   = hold;
        hold_v_n = hold_v;
        thr_n    = thr;
        cnt_n    = match_cnt;
        done_n   = done;
        under_n  = underrun;

        if (abort) begin
            state_n  = IDLE;
            hold_v_n = 1'b0;
            done_n   = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        thr_n   = cfg_thresh;
                        cnt_n   = '0;
                        under_n = 1'b0;
                        if (cfg_thresh == '0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = LOAD;
                            done_n  = 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        sr_n    = din;
                        bidx_n  = BW'(W - 1);
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_n   = {sr[W-2:0], 1'b0};
                    bidx_n = bidx - BW'(1);
                    if (hit) begin
                        cnt_n = cnt_inc;
                    end
                    // A hit reaching the threshold wins over reload and
                    // underrun, even on the last bit of a word.
                    if (hit && (cnt_inc == thr)) begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        hold_v_n = 1'b0;
                    end else if (bidx == '0) begin
                        if (hold_v) begin
                            sr_n     = hold;
                            hold_v_n = 1'b0;
                            bidx_n   = BW'(W - 1);
                        end else if (accept) begin
                            sr_n   = din;
                            bidx_n = BW'(W - 1);
                        end else begin
                            under_n = 1'b1;
                            state_n = LOAD;
                        end
                    end else if (accept) begin
                        hold_n   = din;
                        hold_v_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef SEQDET_CTRL_TSTAMP_EN
    logic [15:0] bitcnt;

    // first_hit latches the running bit count on the first hit of a run;
    // match_cnt == 0 identifies that first hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bitcnt    <= '0;
            first_hit <= '1;
        end else if (abort) begin
            bitcnt    <= bitcnt;
            first_hit <= first_hit;
        end else if (((state == IDLE) || (state == DONE)) && start) begin
            bitcnt    <= '0;
            first_hit <= '1;
        end else if (state == SHIFT) begin
            if (bitcnt != 16'hFFFE) begin
                bitcnt <= bitcnt + 16'd1;
            end
            if (det_z && (match_cnt == '0)) begin
                first_hit <= bitcnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// tb_seqdet_stream_ctrl
//   Bench for seqdet_stream_ctrl with W=8, CW=8, driving a 10010 Mealy
//   detector. Directed scenarios are followed by randomized runs. The
//   expected behaviour comes from a bit-queue reference model.

module tb_seqdet_stream_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_thresh;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic          det_x;
    logic          det_rst_n;
    logic          det_z;
    logic          busy;
    logic          done;
    logic          underrun;
    logic [CW-1:0] match_cnt;
`ifdef SEQDET_CTRL_TSTAMP_EN
    logic [15:0]   first_hit;
`endif

    int checks = 0;
    int errors = 0;

    seqdet_stream_ctrl #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_thresh (cfg_thresh),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .det_x      (det_x),
        .det_rst_n  (det_rst_n),
        .det_z      (det_z),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .match_cnt  (match_cnt)
`ifdef SEQDET_CTRL_TSTAMP_EN
        ,
        .first_hit  (first_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 10010 overlapping Mealy detector with synchronous active-low reset.
    typedef enum logic [2:0] {D0, D1, D10, D100, D1001} dstate_t;
    dstate_t ds;

    always_ff @(posedge clk) begin
        if (!det_rst_n) begin
            ds <= D0;
        end else begin
            case (ds)
                D0:      ds <= det_x ? D1 : D0;
                D1:      ds <= det_x ? D1 : D10;
                D10:     ds <= det_x ? D1 : D100;
                D100:    ds <= det_x ? D1001 : D0;
                D1001:   ds <= det_x ? D1 : D10;
                default: ds <= D0;
            endcase
        end
    end
    assign det_z = det_rst_n && (ds == D1001) && !det_x;

    // Reference model: a queue of bits still to be sent, plus run bookkeeping.
    typedef enum int {M_IDLE, M_LOAD, M_SHIFT, M_DONE} mmode_t;
    mmode_t     m_mode  = M_IDLE;
    bit         q[$];
    int         m_cnt   = 0;
    int         m_thr   = 0;
    bit         m_done  = 0;
    bit         m_under = 0;
    logic [15:0] m_fh   = 16'hFFFF;
    int         m_bits  = 0;
    logic [4:0] m_hist  = '0;
    int         m_nh    = 0;

    // Feeder: words to offer, each with an idle gap (cycles) before it.
    logic [W-1:0] wq[$];
    int           gq[$];

    function automatic logic exp_ready();
        return (m_mode == M_LOAD) || ((m_mode == M_SHIFT) && (q.size() <= int'(W)));
    endfunction

    function automatic logic exp_x();
        return (m_mode == M_SHIFT) ? q[0] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("din_ready", 32'(din_ready), 32'(exp_ready()));
        chk("det_x",     32'(det_x),     32'(exp_x()));
        chk("det_rst_n", 32'(det_rst_n), 32'(m_mode == M_SHIFT));
        chk("busy",      32'(busy),      32'((m_mode == M_LOAD) || (m_mode == M_SHIFT)));
        chk("done",      32'(done),      32'(m_done));
        chk("underrun",  32'(underrun),  32'(m_under));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
`ifdef SEQDET_CTRL_TSTAMP_EN
        chk("first_hit", 32'(first_hit), 32'(m_fh));
`endif
    endtask

    task automatic push_word_bits(input logic [W-1:0] w);
        for (int unsigned i = 0; i < W; i++) begin
            q.push_back(w[W-1-i]);
        end
    endtask

    task automatic model_step(input logic acc);
        bit         x;
        bit         hit;
        logic [4:0] h5;
        if (!rst) begin
            m_mode = M_IDLE; q.delete(); m_cnt = 0; m_thr = 0; m_done = 0;
            m_under = 0; m_fh = 16'hFFFF; m_bits = 0;
        end else if (abort) begin
            m_mode = M_IDLE; q.delete(); m_done = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_thr = int'(cfg_thresh); m_cnt = 0; m_under = 0;
                        m_fh = 16'hFFFF; m_bits = 0;
                        if (m_thr == 0) begin
                            m_mode = M_DONE; m_done = 1;
                        end else begin
                            m_mode = M_LOAD; m_done = 0;
                        end
                    end
                end
                M_LOAD: begin
                    if (acc) begin
                        q.delete();
                        push_word_bits(din);
                        m_mode = M_SHIFT; m_hist = '0; m_nh = 0;
                    end
                end
                M_SHIFT: begin
                    x   = q.pop_front();
                    h5  = {m_hist[3:0], x};
                    hit = (m_nh >= 4) && (h5 == 5'b10010);
                    m_hist = h5;
                    m_nh++;
                    if (hit) begin
                        if (m_cnt == 0) m_fh = 16'(m_bits);
                        m_cnt++;
                    end
                    if (m_bits < 32'hFFFE) m_bits++;
                    if (hit && (m_cnt == m_thr)) begin
                        m_mode = M_DONE; m_done = 1; q.delete();
                    end else begin
                        if (acc) push_word_bits(din);
                        if (q.size() == 0) begin
                            m_under = 1; m_mode = M_LOAD;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // One clock: drive the feeder, check outputs at negedge, advance model.
    task automatic cyc();
        logic acc;
        if ((wq.size() > 0) && (gq[0] == 0)) begin
            din_valid = 1'b1;
            din       = wq[0];
        end else begin
            din_valid = 1'b0;
            din       = W'($urandom);
        end
        @(negedge clk);
        check_outputs();
        acc = din_valid && exp_ready();
        model_step(acc);
        if (acc) begin
            void'(wq.pop_front());
            void'(gq.pop_front());
        end else if ((gq.size() > 0) && (gq[0] > 0)) begin
            gq[0] = gq[0] - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic feed(input logic [W-1:0] w, input int gap);
        wq.push_back(w);
        gq.push_back(gap);
    endtask

    task automatic clear_feed();
        wq.delete();
        gq.delete();
    endtask

    task automatic pulse_start(input logic [CW-1:0] thr);
        cfg_thresh = thr;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        clear_feed();
    endtask

    function automatic logic [W-1:0] pick_word();
        case ($urandom_range(0, 5))
            0: return 8'h92;
            1: return 8'h49;
            2: return 8'h24;
            3: return 8'h12;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic int pick_gap();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
    endfunction

    initial begin
        rst = 1'b0; start = 1'b1; abort = 1'b0; cfg_thresh = '0;
        din = '0; din_valid = 1'b0;

        // Reset held with start and a valid word present.
        feed(8'hFF, 0);
        run(2);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_rstn",  32'(det_rst_n), 32'd0);
        chk("reset_ready", 32'(din_ready), 32'd0);
        rst = 1'b1; start = 1'b0;
        clear_feed();
        run(2);

        // Single word 1001_0010 with threshold 2: hits at bits 5 and 8.
        feed(8'b1001_0010, 0);
        pulse_start(8'd2);
        run(12);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_cnt",  32'(match_cnt), 32'd2);
`ifdef SEQDET_CTRL_TSTAMP_EN
        chk("t2_first_hit", 32'(first_hit), 32'd4);
`endif
        clear_feed();

        // A5 then 92 back to back: 1010010110010010 contains three hits.
        feed(8'hA5, 0);
        feed(8'h92, 0);
        pulse_start(8'd3);
        run(22);
        chk("t3_cnt",  32'(match_cnt), 32'd3);
        chk("t3_done", 32'(done), 32'd1);
        clear_feed();

        // 0000_1001 then 0010_0000 arriving three cycles after the last bit.
        feed(8'b0000_1001, 0);
        feed(8'b0010_0000, 10);
        pulse_start(8'd5);
        run(30);
        chk("t4_under", 32'(underrun), 32'd1);
        chk("t4_cnt",   32'(match_cnt), 32'd0);
        chk("t4_busy",  32'(busy), 32'd1);
        pulse_abort();

        // Zero threshold finishes at once and never takes a word.
        feed(8'h92, 0);
        pulse_start(8'd0);
        run(4);
        chk("t5_done",  32'(done), 32'd1);
        chk("t5_cnt",   32'(match_cnt), 32'd0);
        chk("t5_ready", 32'(din_ready), 32'd0);
        clear_feed();

        // Abort mid-word after two hits, then re-arm.
        feed(8'h92, 0);
        feed(8'h92, 0);
        pulse_start(8'd5);
        run(11);
        pulse_abort();
        chk("t6_ready", 32'(din_ready), 32'd0);
        chk("t6_rstn",  32'(det_rst_n), 32'd0);
        chk("t6_busy",  32'(busy), 32'd0);
        chk("t6_cnt",   32'(match_cnt), 32'd2);
        pulse_start(8'd5);
        chk("t6_rearm_cnt",  32'(match_cnt), 32'd0);
        chk("t6_rearm_busy", 32'(busy), 32'd1);
        pulse_abort();

        // Randomized runs with random gaps, starts, aborts and resets.
        for (int r = 0; r < 40; r++) begin
            clear_feed();
            for (int k = 0; k < 8; k++) feed(pick_word(), pick_gap());
            pulse_start(CW'($urandom_range(0, 6)));
            for (int c = 0; c < int'($urandom_range(30, 150)); c++) begin
                start      = ($urandom_range(0, 29) == 0);
                abort      = ($urandom_range(0, 79) == 0);
                rst        = !($urandom_range(0, 199) == 0);
                cfg_thresh = CW'($urandom_range(0, 6));
                cyc();
            end
            start = 1'b0; abort = 1'b0; rst = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
